// File: rtl/max_stream_driver.sv
// max_stream_driver: initiator for the find-maximum operand-stream protocol.
// Buffers host operand pairs, streams them after go and returns the receiver's maximum.
module max_stream_driver #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_a,
    input  logic [7:0] wr_b,
    input  logic [2:0] cfg_instr,
    input  logic       go,
    input  logic       stall,
    input  logic       finish,
    input  logic [7:0] maximum,
    output logic       start,
    output logic       valid,
    output logic       one_left,
    output logic [2:0] instruction,
    output logic [7:0] Data_A,
    output logic [7:0] Data_B,
    output logic       full,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       err_timeout
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ZERO_CNT = (AW + 1)'(0);
    localparam logic [AW:0]   ONE_CNT  = (AW + 1)'(1);
    localparam logic [AW:0]   TWO_CNT  = (AW + 1)'(2);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, STREAM = 2'd2, WAIT = 2'd3} state_t;

    state_t        state_q, state_d;
    logic [15:0]   mem_q [DEPTH];
    logic          mem_we_s;
    logic [AW:0]   count_q, count_d, rem_q, rem_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          bubble_q, bubble_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          start_q, start_d, valid_q, valid_d, one_left_q, one_left_d;
    logic [2:0]    instr_q, instr_d;
    logic [7:0]    data_a_q, data_a_d, data_b_q, data_b_d, result_q, result_d;
    logic          full_q, full_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

    // Operand-pair storage; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[wr_ptr_q] <= {wr_a, wr_b};
        end
    end

    // Next-state and next-output logic; outputs describe the cycle being entered.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rem_d      = rem_q;
        bubble_d   = bubble_q;
        tcnt_d     = tcnt_q;
        mem_we_s   = 1'b0;
        start_d    = 1'b0;
        valid_d    = 1'b0;
        one_left_d = 1'b0;
        instr_d    = instr_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        result_d   = result_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_en && (count_q != FULL_CNT)) begin
                    mem_we_s = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    count_d  = count_q + 1'b1;
                end else begin
                    mem_we_s = 1'b0;
                end
                if (go && (count_q != ZERO_CNT)) begin
                    state_d  = START;
                    start_d  = 1'b1;
                    instr_d  = cfg_instr;
                    rem_d    = count_q;
                    bubble_d = (count_q == ONE_CNT);
                end else begin
                    state_d = IDLE;
                end
            end
            START, STREAM: begin
                state_d = STREAM;
                if (stall) begin
                    valid_d = 1'b0;
                end else if (bubble_q) begin
                    // A single-pair job still needs the one_left marker ahead of its beat.
                    bubble_d   = 1'b0;
                    one_left_d = 1'b1;
                end else begin
                    valid_d    = 1'b1;
                    {data_a_d, data_b_d} = mem_q[rd_ptr_q];
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    rem_d      = rem_q - 1'b1;
                    one_left_d = (rem_q == TWO_CNT);
                    if (rem_q == ONE_CNT) begin
                        state_d = WAIT;
                        tcnt_d  = TW'(0);
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            WAIT: begin
                if (finish) begin
                    result_d = maximum;
                    done_d   = 1'b1;
                    count_d  = ZERO_CNT;
                    wr_ptr_d = AW'(0);
                    rd_ptr_d = AW'(0);
                    instr_d  = 3'd0;
                    state_d  = IDLE;
                end else if (tcnt_q == TMO_LAST) begin
                    err_d    = 1'b1;
                    count_d  = ZERO_CNT;
                    wr_ptr_d = AW'(0);
                    rd_ptr_d = AW'(0);
                    instr_d  = 3'd0;
                    state_d  = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        full_d = (count_d == FULL_CNT);
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= ZERO_CNT;
            wr_ptr_q   <= AW'(0);
            rd_ptr_q   <= AW'(0);
            rem_q      <= ZERO_CNT;
            bubble_q   <= 1'b0;
            tcnt_q     <= TW'(0);
            start_q    <= 1'b0;
            valid_q    <= 1'b0;
            one_left_q <= 1'b0;
            instr_q    <= 3'd0;
            data_a_q   <= 8'd0;
            data_b_q   <= 8'd0;
            result_q   <= 8'd0;
            full_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rem_q      <= rem_d;
            bubble_q   <= bubble_d;
            tcnt_q     <= tcnt_d;
            start_q    <= start_d;
            valid_q    <= valid_d;
            one_left_q <= one_left_d;
            instr_q    <= instr_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            result_q   <= result_d;
            full_q     <= full_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign start       = start_q;
    assign valid       = valid_q;
    assign one_left    = one_left_q;
    assign instruction = instr_q;
    assign Data_A      = data_a_q;
    assign Data_B      = data_b_q;
    assign full        = full_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign err_timeout = err_q;
endmodule

// File: tb/tb_max_stream_driver.sv
// Bench for max_stream_driver: job-level reference model, per-cycle output compare,
// and directed scenarios pinned with hand-computed values.
module tb_max_stream_driver;
    logic clk = 1'b0;
    logic rst, wr_en, go, stall, finish;
    logic [7:0] wr_a, wr_b, maximum;
    logic [2:0] cfg_instr;
    logic start, valid, one_left, full, busy, done, err_timeout;
    logic [2:0] instruction;
    logic [7:0] Data_A, Data_B, result;

    always #5 clk = ~clk;

    max_stream_driver #(.DEPTH(8), .AW(3), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b),
        .cfg_instr(cfg_instr), .go(go), .stall(stall), .finish(finish),
        .maximum(maximum), .start(start), .valid(valid), .one_left(one_left),
        .instruction(instruction), .Data_A(Data_A), .Data_B(Data_B), .full(full),
        .busy(busy), .done(done), .result(result), .err_timeout(err_timeout)
    );

    localparam int P_IDLE = 0, P_START = 1, P_STREAM = 2, P_WAIT = 3;

    int tests = 0;
    int fails = 0;

    // reference model: buffer contents, current job and expected outputs
    logic [15:0] m_buf[$];
    logic [15:0] m_job[$];
    int m_phase, m_n, m_beats, m_wait;
    bit m_bubble;
    logic e_start, e_valid, e_one_left, e_full, e_busy, e_done, e_err;
    logic [2:0] e_instr;
    logic [7:0] e_da, e_db, e_result;

    int obs_beats, obs_ol, tick_no, last_beat_tick, err_tick;
    bit job_done_seen;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_buf.delete();
        m_job.delete();
        m_phase = P_IDLE; m_n = 0; m_beats = 0; m_wait = 0; m_bubble = 0;
        e_start = 0; e_valid = 0; e_one_left = 0; e_full = 0; e_busy = 0;
        e_done = 0; e_err = 0; e_instr = 3'd0; e_da = 8'd0; e_db = 8'd0; e_result = 8'd0;
    endtask

    function automatic logic [7:0] apply_op(input logic [2:0] op, input logic [15:0] p);
        if (op == 3'b010) return p[15:8] & p[7:0];
        return p[15:8] + p[7:0];
    endfunction

    function automatic logic [7:0] calc_max(input logic [2:0] op);
        logic [7:0] mx = 8'd0;
        foreach (m_buf[i]) if (apply_op(op, m_buf[i]) > mx) mx = apply_op(op, m_buf[i]);
        return mx;
    endfunction

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic model_step();
        int n0;
        if (rst) begin model_reset(); return; end
        e_start = 0; e_valid = 0; e_one_left = 0; e_done = 0; e_err = 0;
        case (m_phase)
            P_IDLE: begin
                n0 = m_buf.size();
                if (wr_en && n0 < 8) m_buf.push_back({wr_a, wr_b});
                if (go && n0 >= 1) begin
                    m_job.delete();
                    for (int i = 0; i < n0; i++) m_job.push_back(m_buf[i]);
                    m_n = n0; m_beats = 0; m_bubble = (n0 == 1);
                    m_phase = P_START; e_start = 1; e_instr = cfg_instr;
                end
            end
            P_START, P_STREAM: begin
                m_phase = P_STREAM;
                if (!stall) begin
                    if (m_bubble) begin
                        m_bubble = 0; e_one_left = 1;
                    end else begin
                        e_valid = 1;
                        {e_da, e_db} = m_job[m_beats];
                        m_beats++;
                        e_one_left = (m_n >= 2) && (m_beats == m_n - 1);
                        if (m_beats == m_n) begin m_phase = P_WAIT; m_wait = 0; end
                    end
                end
            end
            default: begin
                if (finish) begin
                    e_result = maximum; e_done = 1; m_buf.delete(); m_phase = P_IDLE; e_instr = 3'd0;
                end else begin
                    m_wait++;
                    if (m_wait == 15) begin
                        e_err = 1; m_buf.delete(); m_phase = P_IDLE; e_instr = 3'd0;
                    end
                end
            end
        endcase
        e_full = (m_buf.size() == 8);
        e_busy = (m_phase != P_IDLE);
    endtask

    always @(negedge clk) begin
        chk("outputs", {start, valid, one_left, instruction, Data_A, Data_B, full, busy, done, result, err_timeout},
            {e_start, e_valid, e_one_left, e_instr, e_da, e_db, e_full, e_busy, e_done, e_result, e_err});
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        tick_no++;
        if (valid) begin obs_beats++; last_beat_tick = tick_no; end
        if (one_left) obs_ol = obs_beats;
        if (err_timeout) err_tick = tick_no;
    endtask

    task automatic set_idle();
        wr_en = 0; go = 0; stall = 0; finish = 0;
        maximum = 8'($urandom); wr_a = 8'($urandom); wr_b = 8'($urandom);
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b);
        wr_en = 1; wr_a = a; wr_b = b;
        finish = 1'($urandom_range(0, 1)); maximum = 8'($urandom);
        tick();
        set_idle();
    endtask

    task automatic run_job(input logic [2:0] instr, input int stall_mode, input int fin_delay, input bit no_fin);
        logic [7:0] mx;
        int budget, st_ticks, wt;
        mx = calc_max(instr);
        obs_beats = 0; obs_ol = -1; err_tick = -1; last_beat_tick = -1; job_done_seen = 0;
        cfg_instr = instr; go = 1;
        tick();
        go = 0; cfg_instr = 3'($urandom);
        budget = 0; st_ticks = 0; wt = 0;
        while (m_phase != P_IDLE && budget < 200) begin
            wr_en = 1'($urandom_range(0, 1)); wr_a = 8'($urandom); wr_b = 8'($urandom);
            go = 1'($urandom_range(0, 1)); stall = 0; finish = 0; maximum = 8'($urandom);
            if (m_phase == P_START || m_phase == P_STREAM) begin
                if (stall_mode == 1) stall = (st_ticks == 2 || st_ticks == 3);
                else if (stall_mode == 2) stall = ($urandom_range(0, 3) == 0);
                finish = ($urandom_range(0, 7) == 0);
                st_ticks++;
            end else if (!no_fin && wt == fin_delay) begin
                finish = 1; maximum = mx; wt++;
            end else begin
                wt++;
            end
            tick();
            budget++;
        end
        job_done_seen = done;
        set_idle();
        chk("job_returns_idle", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick_no = 0;
        set_idle(); cfg_instr = 3'd0; rst = 1; model_reset();
        tick(); tick();
        rst = 0;
        chk("reset_result", result, 0);
        chk("reset_busy_full", {busy, full}, 0);

        // three pairs, add opcode: sums 8,12,14
        load(8'd3, 8'd5); load(8'd10, 8'd2); load(8'd7, 8'd7);
        run_job(3'b000, 0, 2, 0);
        chk("t1_result", result, 8'd14);
        chk("t1_beats", obs_beats, 3);
        chk("t1_one_left_beat", obs_ol, 2);
        chk("t1_done", job_done_seen, 1);

        // single pair, AND opcode: F0 & 3C = 30
        load(8'hF0, 8'h3C);
        run_job(3'b010, 0, 0, 0);
        chk("t2_result", result, 8'h30);
        chk("t2_beats", obs_beats, 1);
        chk("t2_one_left_bubble", obs_ol, 0);

        // four pairs with two stall cycles mid-stream: sums 3,50,10,101
        load(8'd1, 8'd2); load(8'd20, 8'd30); load(8'd5, 8'd5); load(8'd100, 8'd1);
        run_job(3'b000, 1, 1, 0);
        chk("t3_result", result, 8'd101);
        chk("t3_beats", obs_beats, 4);
        chk("t3_one_left_beat", obs_ol, 3);

        // nine writes into eight entries: sums 11*i, ninth dropped
        for (int i = 1; i <= 9; i++) begin
            load(8'(i * 10), 8'(i));
            if (i >= 8) chk("t4_full", full, 1);
        end
        run_job(3'b000, 0, 3, 0);
        chk("t4_result", result, 8'd88);
        chk("t4_beats", obs_beats, 8);
        chk("t4_one_left_beat", obs_ol, 7);

        // no finish: timeout fires 15 cycles after WAIT entry
        load(8'd1, 8'd1);
        run_job(3'b000, 0, 0, 1);
        chk("t5_timeout_gap", err_tick - last_beat_tick, 15);
        chk("t5_result_kept", result, 8'd88);
        chk("t5_no_done", job_done_seen, 0);
        go = 1;
        tick();
        go = 0;
        chk("t5_empty_go_ignored", {start, busy, full}, 0);
        tick();

        // reset in the middle of the stream
        load(8'd1, 8'd1); load(8'd2, 8'd2); load(8'd3, 8'd3); load(8'd4, 8'd4); load(8'd5, 8'd5);
        obs_beats = 0;
        cfg_instr = 3'd0; go = 1;
        tick();
        go = 0;
        for (int k = 0; k < 20 && obs_beats < 2; k++) tick();
        chk("t6_reached_beat2", obs_beats, 2);
        #2 rst = 1;
        model_reset();
        #1 chk("t6_async_reset", {start, valid, one_left, instruction, Data_A, Data_B, full, busy, done, result, err_timeout}, 0);
        tick(); tick();
        rst = 0;
        load(8'd9, 8'd9); load(8'd2, 8'd3);
        run_job(3'b000, 0, 1, 0);
        chk("t6_fresh_result", result, 8'd18);
        chk("t6_fresh_beats", obs_beats, 2);

        // randomized jobs
        for (int j = 0; j < 40; j++) begin
            int n;
            n = $urandom_range(1, 10);
            for (int k = 0; k < n; k++) load(8'($urandom), 8'($urandom));
            if ($urandom_range(0, 1) == 1) tick();
            run_job(($urandom_range(0, 1) == 1) ? 3'b010 : 3'b000, 2,
                    $urandom_range(0, 5), ($urandom_range(0, 7) == 0));
            chk("rand_beats", obs_beats, (n > 8) ? 8 : n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
